// File: rtl/cache_wb.sv
// Write-back direct-mapped cache between the CPU load/store port and a burst memory.
// Dirty victims are written back and whole lines refilled; one request in flight.
module cache_wb #(
  parameter int LINE_IX_BITWIDTH   = 8,
  parameter int COLUMN_IX_BITWIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [3:0]  req_strobe,
  input  logic [31:0] req_data,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic        mem_cmd_write,
  output logic [31:0] mem_cmd_address,
  output logic [31:0] mem_wdata,
  output logic        mem_wvalid,
  input  logic        mem_wready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
);
  localparam int TAG_BITWIDTH = 32 - LINE_IX_BITWIDTH - COLUMN_IX_BITWIDTH - 2;
  localparam int LINES        = 2 ** LINE_IX_BITWIDTH;
  localparam int COLUMNS      = 2 ** COLUMN_IX_BITWIDTH;
  localparam int DIX_BITWIDTH = LINE_IX_BITWIDTH + COLUMN_IX_BITWIDTH;
  localparam int ENTRY_BITS   = TAG_BITWIDTH + 2;
  localparam int OFF_BITS     = COLUMN_IX_BITWIDTH + 2;

  localparam logic [COLUMN_IX_BITWIDTH-1:0] LAST_COL  = COLUMN_IX_BITWIDTH'(COLUMNS - 1);
  localparam logic [COLUMN_IX_BITWIDTH-1:0] COL_ONE   = COLUMN_IX_BITWIDTH'(1);
  localparam logic [LINE_IX_BITWIDTH-1:0]   LAST_LINE = LINE_IX_BITWIDTH'(LINES - 1);
  localparam logic [LINE_IX_BITWIDTH-1:0]   LINE_ONE  = LINE_IX_BITWIDTH'(1);
  localparam logic [OFF_BITS-1:0]           OFF_ZERO  = '0;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    LOOKUP  = 3'd2,
    WB_CMD  = 3'd3,
    WB_DATA = 3'd4,
    RF_CMD  = 3'd5,
    RF_DATA = 3'd6,
    RESPOND = 3'd7
  } state_t;

  state_t                        state_r;
  logic [LINE_IX_BITWIDTH-1:0]   init_ix_r;
  logic [29:0]                   req_addr_r;
  logic                          req_write_r;
  logic [3:0]                    req_strobe_r;
  logic [31:0]                   req_data_r;
  logic                          replay_r;
  logic [COLUMN_IX_BITWIDTH-1:0] col_r;
  logic                          fetch_r;
  logic [31:0]                   refill_word_r;
  logic                          req_ready_r;
  logic                          resp_valid_r;
  logic [31:0]                   resp_data_r;
  logic                          cmd_valid_r;
  logic                          cmd_write_r;
  logic [31:0]                   cmd_address_r;
  logic                          wvalid_r;
  logic [31:0]                   wdata_r;

  logic [ENTRY_BITS-1:0] tag_mem [LINES];
  logic [ENTRY_BITS-1:0] tag_rdata_r;
  logic [31:0]           data_mem [LINES*COLUMNS];
  logic [31:0]           data_rdata_r;

  logic                          tag_we_s;
  logic                          tag_re_s;
  logic [LINE_IX_BITWIDTH-1:0]   tag_addr_s;
  logic [ENTRY_BITS-1:0]         tag_wdata_s;
  logic                          data_re_s;
  logic [3:0]                    data_we_s;
  logic [DIX_BITWIDTH-1:0]       data_addr_s;
  logic [31:0]                   data_wdata_s;

  logic [TAG_BITWIDTH-1:0]       req_tag_s;
  logic [LINE_IX_BITWIDTH-1:0]   req_line_s;
  logic [COLUMN_IX_BITWIDTH-1:0] req_col_s;
  logic                          victim_valid_s;
  logic                          victim_dirty_s;
  logic [TAG_BITWIDTH-1:0]       victim_tag_s;
  logic                          hit_s;
  logic [31:0]                   word_s;
  logic                          unused_s;

  assign unused_s = ^req_address[1:0];

  assign req_tag_s      = req_addr_r[29 -: TAG_BITWIDTH];
  assign req_line_s     = req_addr_r[COLUMN_IX_BITWIDTH +: LINE_IX_BITWIDTH];
  assign req_col_s      = req_addr_r[COLUMN_IX_BITWIDTH-1:0];
  assign victim_valid_s = tag_rdata_r[ENTRY_BITS-1];
  assign victim_dirty_s = tag_rdata_r[ENTRY_BITS-2];
  assign victim_tag_s   = tag_rdata_r[TAG_BITWIDTH-1:0];
  // A replay after refill is a guaranteed hit whose word was captured off the burst.
  assign hit_s  = replay_r | (victim_valid_s & (victim_tag_s == req_tag_s));
  assign word_s = replay_r ? refill_word_r : data_rdata_r;

  assign req_ready       = req_ready_r;
  assign resp_valid      = resp_valid_r;
  assign resp_data       = resp_data_r;
  assign mem_cmd_valid   = cmd_valid_r;
  assign mem_cmd_write   = cmd_write_r;
  assign mem_cmd_address = cmd_address_r;
  assign mem_wvalid      = wvalid_r;
  assign mem_wdata       = wdata_r;

  // Tag/data store port control for the current state.
  always_comb begin
    tag_we_s     = 1'b0;
    tag_re_s     = 1'b0;
    tag_addr_s   = req_line_s;
    tag_wdata_s  = '0;
    data_re_s    = 1'b0;
    data_we_s    = 4'b0000;
    data_addr_s  = {req_line_s, req_col_s};
    data_wdata_s = req_data_r;
    case (state_r)
      INIT: begin
        tag_we_s   = 1'b1;
        tag_addr_s = init_ix_r;
      end
      IDLE: begin
        if (req_valid && req_ready_r) begin
          tag_re_s    = 1'b1;
          data_re_s   = 1'b1;
          tag_addr_s  = req_address[OFF_BITS +: LINE_IX_BITWIDTH];
          data_addr_s = req_address[2 +: DIX_BITWIDTH];
        end else begin
          tag_re_s = 1'b0;
        end
      end
      LOOKUP: begin
        if (hit_s && req_write_r) begin
          data_we_s   = req_strobe_r;
          tag_we_s    = 1'b1;
          tag_wdata_s = {1'b1, 1'b1, req_tag_s};
        end else if (!hit_s && victim_valid_s && victim_dirty_s) begin
          data_re_s   = 1'b1;
          data_addr_s = {req_line_s, {COLUMN_IX_BITWIDTH{1'b0}}};
        end else begin
          data_re_s = 1'b0;
        end
      end
      WB_DATA: begin
        if (wvalid_r && mem_wready && (col_r != LAST_COL)) begin
          data_re_s   = 1'b1;
          data_addr_s = {req_line_s, col_r + COL_ONE};
        end else begin
          data_re_s = 1'b0;
        end
      end
      RF_DATA: begin
        if (mem_rvalid) begin
          data_we_s    = 4'b1111;
          data_addr_s  = {req_line_s, col_r};
          data_wdata_s = mem_rdata;
          tag_we_s     = (col_r == LAST_COL);
          tag_wdata_s  = {1'b1, 1'b0, req_tag_s};
        end else begin
          data_we_s = 4'b0000;
        end
      end
      default: begin
        tag_we_s = 1'b0;
      end
    endcase
  end

  // Single-port synchronous tag and byte-writable data stores.
  always_ff @(posedge clk) begin
    if (tag_we_s) begin
      tag_mem[tag_addr_s] <= tag_wdata_s;
    end
    if (tag_re_s) begin
      tag_rdata_r <= tag_mem[tag_addr_s];
    end
    for (int b = 0; b < 4; b++) begin
      if (data_we_s[b]) begin
        data_mem[data_addr_s][8*b +: 8] <= data_wdata_s[8*b +: 8];
      end
    end
    if (data_re_s) begin
      data_rdata_r <= data_mem[data_addr_s];
    end
  end

  // Control FSM with registered CPU and memory-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= INIT;
      init_ix_r     <= '0;
      req_addr_r    <= '0;
      req_write_r   <= 1'b0;
      req_strobe_r  <= 4'b0000;
      req_data_r    <= 32'h0000_0000;
      replay_r      <= 1'b0;
      col_r         <= '0;
      fetch_r       <= 1'b0;
      refill_word_r <= 32'h0000_0000;
      req_ready_r   <= 1'b0;
      resp_valid_r  <= 1'b0;
      resp_data_r   <= 32'h0000_0000;
      cmd_valid_r   <= 1'b0;
      cmd_write_r   <= 1'b0;
      cmd_address_r <= 32'h0000_0000;
      wvalid_r      <= 1'b0;
      wdata_r       <= 32'h0000_0000;
    end else begin
      case (state_r)
        INIT: begin
          init_ix_r <= init_ix_r + LINE_ONE;
          if (init_ix_r == LAST_LINE) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
          end
        end
        IDLE: begin
          if (req_valid && req_ready_r) begin
            req_addr_r   <= req_address[31:2];
            req_write_r  <= req_write;
            req_strobe_r <= req_strobe;
            req_data_r   <= req_data;
            replay_r     <= 1'b0;
            req_ready_r  <= 1'b0;
            state_r      <= LOOKUP;
          end
        end
        LOOKUP: begin
          replay_r <= 1'b0;
          if (hit_s) begin
            resp_valid_r <= 1'b1;
            resp_data_r  <= word_s;
            state_r      <= RESPOND;
          end else if (victim_valid_s && victim_dirty_s) begin
            cmd_valid_r   <= 1'b1;
            cmd_write_r   <= 1'b1;
            cmd_address_r <= {victim_tag_s, req_line_s, OFF_ZERO};
            state_r       <= WB_CMD;
          end else begin
            cmd_valid_r   <= 1'b1;
            cmd_write_r   <= 1'b0;
            cmd_address_r <= {req_tag_s, req_line_s, OFF_ZERO};
            state_r       <= RF_CMD;
          end
        end
        WB_CMD: begin
          // Column 0 was read during LOOKUP and is held in the read register.
          if (mem_cmd_ready) begin
            cmd_valid_r <= 1'b0;
            col_r       <= '0;
            wvalid_r    <= 1'b1;
            wdata_r     <= data_rdata_r;
            state_r     <= WB_DATA;
          end
        end
        WB_DATA: begin
          if (wvalid_r && mem_wready) begin
            wvalid_r <= 1'b0;
            if (col_r == LAST_COL) begin
              col_r         <= '0;
              cmd_valid_r   <= 1'b1;
              cmd_write_r   <= 1'b0;
              cmd_address_r <= {req_tag_s, req_line_s, OFF_ZERO};
              state_r       <= RF_CMD;
            end else begin
              col_r   <= col_r + COL_ONE;
              fetch_r <= 1'b1;
            end
          end else if (fetch_r) begin
            fetch_r  <= 1'b0;
            wvalid_r <= 1'b1;
            wdata_r  <= data_rdata_r;
          end
        end
        RF_CMD: begin
          if (mem_cmd_ready) begin
            cmd_valid_r <= 1'b0;
            col_r       <= '0;
            state_r     <= RF_DATA;
          end
        end
        RF_DATA: begin
          if (mem_rvalid) begin
            if (col_r == req_col_s) begin
              refill_word_r <= mem_rdata;
            end
            if (col_r == LAST_COL) begin
              col_r    <= '0;
              replay_r <= 1'b1;
              state_r  <= LOOKUP;
            end else begin
              col_r <= col_r + COL_ONE;
            end
          end
        end
        RESPOND: begin
          resp_valid_r <= 1'b0;
          req_ready_r  <= 1'b1;
          state_r      <= IDLE;
        end
        default: begin
          state_r     <= INIT;
          init_ix_r   <= '0;
          req_ready_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cache_wb.sv
// Directed bench for cache_wb: a burst-memory responder plus scoreboard queues for
// load data, memory commands and write-back words.
module tb_cache_wb;
  localparam int COLUMNS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_address;
  logic [3:0]  req_strobe;
  logic [31:0] req_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready;
  logic        mem_cmd_write;
  logic [31:0] mem_cmd_address;
  logic [31:0] mem_wdata;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  always #5 clk = ~clk;

  cache_wb dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_strobe(req_strobe), .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_write(mem_cmd_write), .mem_cmd_address(mem_cmd_address),
    .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  int checks = 0;
  int errors = 0;
  int cmd_delay = 0;
  bit wr_toggle = 1'b0;
  int cmd_count = 0;
  int rd_beats = 0;

  logic [31:0] mem_model [logic [31:0]];
  logic [32:0] exp_cmd_q [$];
  logic [31:0] exp_wb_q [$];
  logic [31:0] exp_rd_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Burst memory: acts half a cycle before each rising edge, records handshakes it grants.
  initial begin : responder
    int mst;
    int beat;
    int wait_cnt;
    bit have_first;
    bit tog;
    logic first_wr;
    logic cur_wr;
    logic [31:0] first_addr;
    logic [31:0] cur_addr;
    logic [32:0] ec;
    logic [31:0] ew;
    mst = 0; beat = 0; wait_cnt = 0; have_first = 1'b0; tog = 1'b0;
    first_wr = 1'b0; cur_wr = 1'b0; first_addr = 32'd0; cur_addr = 32'd0;
    mem_cmd_ready = 1'b0; mem_rvalid = 1'b0; mem_wready = 1'b0; mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      #1;
      if (rst === 1'b1) begin
        mst = 0; beat = 0; wait_cnt = 0; have_first = 1'b0;
        mem_cmd_ready = 1'b0; mem_rvalid = 1'b0; mem_wready = 1'b0;
      end else begin
        mem_cmd_ready = 1'b0;
        case (mst)
          0: begin
            mem_rvalid = 1'b0;
            mem_wready = 1'b0;
            if (mem_cmd_valid === 1'b1) begin
              if (!have_first) begin
                have_first = 1'b1;
                first_wr = mem_cmd_write;
                first_addr = mem_cmd_address;
              end else begin
                chk("cmd_write_stable", 32'(mem_cmd_write), 32'(first_wr));
                chk("cmd_addr_stable", mem_cmd_address, first_addr);
              end
              if (wait_cnt < cmd_delay) begin
                wait_cnt++;
              end else begin
                mem_cmd_ready = 1'b1;
                cmd_count++;
                cur_wr = mem_cmd_write;
                cur_addr = mem_cmd_address;
                chk("cmd_expected", 32'(exp_cmd_q.size() > 0), 32'd1);
                if (exp_cmd_q.size() > 0) begin
                  ec = exp_cmd_q.pop_front();
                  chk("cmd_write", 32'(cur_wr), 32'(ec[32]));
                  chk("cmd_addr", cur_addr, ec[31:0]);
                end
                have_first = 1'b0; wait_cnt = 0; beat = 0; rd_beats = 0;
                mst = cur_wr ? 2 : 1;
              end
            end
          end
          1: begin
            if (beat < COLUMNS) begin
              mem_rvalid = 1'b1;
              mem_rdata = mem_model[cur_addr + 32'(4 * beat)];
              beat++;
              rd_beats = beat;
            end else begin
              mem_rvalid = 1'b0;
              mst = 0;
            end
          end
          default: begin
            if (beat >= COLUMNS) begin
              mem_wready = 1'b0;
              mst = 0;
            end else if (mem_wvalid === 1'b1) begin
              tog = wr_toggle ? ~tog : 1'b1;
              mem_wready = tog;
              if (tog) begin
                chk("wb_expected", 32'(exp_wb_q.size() > 0), 32'd1);
                if (exp_wb_q.size() > 0) begin
                  ew = exp_wb_q.pop_front();
                  chk("wb_word", mem_wdata, ew);
                end
                mem_model[cur_addr + 32'(4 * beat)] = mem_wdata;
                beat++;
              end
            end else begin
              mem_wready = 1'b0;
            end
          end
        endcase
      end
    end
  end

  task automatic sweep_check(input string tag);
    int cnt;
    cnt = 0;
    while (req_ready !== 1'b1 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    chk({tag, "_ready_low_cycles"}, 32'(cnt), 32'd256);
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_data"}, resp_data, 32'd0);
    chk({tag, "_cmd_valid"}, 32'(mem_cmd_valid), 32'd0);
    chk({tag, "_cmd_write"}, 32'(mem_cmd_write), 32'd0);
    chk({tag, "_cmd_address"}, mem_cmd_address, 32'd0);
    chk({tag, "_wvalid"}, 32'(mem_wvalid), 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask

  // Issue one request at a falling edge; exp_lat > 0 demands an exact hit latency.
  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [3:0] strb, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input int exp_lat);
    int n;
    logic [31:0] e;
    if (!wr) exp_rd_q.push_back(exp_rd);
    req_valid = 1'b1; req_write = wr; req_address = addr; req_strobe = strb; req_data = wd;
    n = 0;
    while (req_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (resp_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_resp"}, 32'(resp_valid), 32'd1);
    if (exp_lat > 0) chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    if (!wr && resp_valid === 1'b1 && exp_rd_q.size() > 0) begin
      e = exp_rd_q.pop_front();
      chk({tag, "_data"}, resp_data, e);
    end
    @(negedge clk);
    chk({tag, "_resp_pulse"}, 32'(resp_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin : stim
    int cc;
    int n;
    for (int i = 0; i < 4; i++) begin
      mem_model[32'h0000_0010 + 32'(4*i)] = 32'h0000_00A0 + 32'(i);
      mem_model[32'h0000_0020 + 32'(4*i)] = 32'h0000_0020 + 32'(i);
      mem_model[32'h0000_0000 + 32'(4*i)] = 32'h0000_00B0 + 32'(i);
      mem_model[32'h0000_1000 + 32'(4*i)] = 32'h0000_00C0 + 32'(i);
      mem_model[32'h0000_0040 + 32'(4*i)] = 32'h0000_00D0 + 32'(i);
    end
    mem_model[32'h0000_0020] = 32'h1122_3344;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_address = 32'd0;
    req_strobe = 4'b0000; req_data = 32'd0;
    repeat (3) @(negedge clk);
    reset_values("por");
    rst = 1'b0;
    sweep_check("sweep0");

    exp_cmd_q.push_back({1'b0, 32'h0000_0010});
    do_req("cold_load10", 1'b0, 32'h0000_0010, 4'b0000, 32'd0, 32'h0000_00A0, 0);
    cc = cmd_count;
    do_req("hit_load14", 1'b0, 32'h0000_0014, 4'b0000, 32'd0, 32'h0000_00A1, 2);
    chk("hit_no_traffic", 32'(cmd_count), 32'(cc));

    exp_cmd_q.push_back({1'b0, 32'h0000_0020});
    do_req("cold_load20", 1'b0, 32'h0000_0020, 4'b0000, 32'd0, 32'h1122_3344, 0);
    cc = cmd_count;
    do_req("hit_store20", 1'b1, 32'h0000_0020, 4'b0011, 32'hDEAD_BEEF, 32'd0, 2);
    do_req("hit_load20", 1'b0, 32'h0000_0020, 4'b0000, 32'd0, 32'h1122_BEEF, 2);
    chk("store_no_traffic", 32'(cmd_count), 32'(cc));

    exp_cmd_q.push_back({1'b0, 32'h0000_0000});
    do_req("miss_store00", 1'b1, 32'h0000_0000, 4'b1100, 32'h5566_7788, 32'd0, 0);

    cmd_delay = 5;
    wr_toggle = 1'b1;
    exp_cmd_q.push_back({1'b1, 32'h0000_0000});
    exp_cmd_q.push_back({1'b0, 32'h0000_1000});
    exp_wb_q.push_back(32'h5566_00B0);
    exp_wb_q.push_back(32'h0000_00B1);
    exp_wb_q.push_back(32'h0000_00B2);
    exp_wb_q.push_back(32'h0000_00B3);
    do_req("evict_load1000", 1'b0, 32'h0000_1000, 4'b0000, 32'd0, 32'h0000_00C0, 0);
    chk("wb_all_words", 32'(exp_wb_q.size()), 32'd0);
    cmd_delay = 0;
    wr_toggle = 1'b0;

    exp_cmd_q.push_back({1'b0, 32'h0000_0000});
    do_req("clean_reload00", 1'b0, 32'h0000_0000, 4'b0000, 32'd0, 32'h5566_00B0, 0);

    exp_cmd_q.push_back({1'b0, 32'h0000_0040});
    rd_beats = 0;
    req_valid = 1'b1; req_write = 1'b0; req_address = 32'h0000_0044;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_accept", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (rd_beats < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_in_burst", 32'(rd_beats >= 2), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    reset_values("midrst");
    rst = 1'b0;
    sweep_check("sweep1");
    exp_cmd_q.push_back({1'b0, 32'h0000_0040});
    cc = cmd_count;
    do_req("after_rst_load44", 1'b0, 32'h0000_0044, 4'b0000, 32'd0, 32'h0000_00D1, 0);
    chk("after_rst_missed", 32'(cmd_count), 32'(cc + 1));

    chk("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cache_wb.md
# cache_wb

Parametrised, write-back, direct-mapped cache between the CPU load/store port and burst-capable backing memory (SDRAM/PSRAM controller). Generalises the single-cycle write-through tag/data cache: configurable line count and words per line, valid/dirty tracking, byte-write strobes, a reset-time tag sweep, and a miss engine that writes back dirty victims and refills whole lines over a command/data handshake. Sits in the CPU memory path; one outstanding request at a time.

## Interface
Parameters:
- LINE_IX_BITWIDTH, 8, log2 of line count (LINES = 2**LINE_IX_BITWIDTH)
- COLUMN_IX_BITWIDTH, 2, log2 of 32-bit words per line (COLUMNS = 2**COLUMN_IX_BITWIDTH)
- TAG_BITWIDTH, derived = 32 - LINE_IX_BITWIDTH - COLUMN_IX_BITWIDTH - 2, not overridable

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  cache can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_address  in  32  byte address; bits [1:0] ignored
- req_strobe  in  4  byte enables for stores (bit i -> data[8i+7:8i])
- req_data  in  32  store data
- resp_valid  out  1  one-cycle pulse: load data valid / store complete
- resp_data  out  32  load data, valid only with resp_valid
- mem_cmd_valid  out  1  burst command present
- mem_cmd_ready  in  1  memory accepts command
- mem_cmd_write  out  1  1 = burst write, 0 = burst read
- mem_cmd_address  out  32  line-aligned byte address (low COLUMN_IX_BITWIDTH+2 bits zero)
- mem_wdata  out  32  write-burst word
- mem_wvalid  out  1  mem_wdata valid
- mem_wready  in  1  memory accepts write word
- mem_rdata  in  32  read-burst word
- mem_rvalid  in  1  read word valid; no backpressure, cache always accepts

## Operation
- Address split: [1:0] byte, next COLUMN_IX_BITWIDTH column, next LINE_IX_BITWIDTH line, top TAG_BITWIDTH tag.
- Tag store entry per line: {valid, dirty, tag}. Data store: COLUMNS word-wide SPBRAM banks indexed by line, byte-writable.
- States: INIT, IDLE, LOOKUP, WB_CMD, WB_DATA, RF_CMD, RF_DATA, RESPOND.
- INIT: entered on reset; writes {0,0,0} to every tag entry, line 0 .. LINES-1, one per cycle; then IDLE.
- IDLE: req_ready=1. Request accepted when req_valid & req_ready; all req_* fields registered; BRAM read issued; -> LOOKUP.
- LOOKUP: hit = valid & tag match.
  - Hit load: resp_data = selected column word; -> RESPOND.
  - Hit store: write req_data to selected column under req_strobe, set dirty; -> RESPOND.
  - Miss, victim valid & dirty -> WB_CMD; otherwise -> RF_CMD.
- WB_CMD: mem_cmd_valid=1, write=1, address = {victim tag, line, zeros}; on mem_cmd_ready -> WB_DATA.
- WB_DATA: stream columns 0..COLUMNS-1 on mem_wdata; advance word on mem_wvalid & mem_wready; mem_wvalid may deassert only while the next word is fetched from BRAM. After last word -> RF_CMD.
- RF_CMD: mem_cmd_valid=1, write=0, address = {request tag, line, zeros}; on mem_cmd_ready -> RF_DATA.
- RF_DATA: each mem_rvalid writes mem_rdata to column 0, 1, ... in order. After last word write tag entry {1,0,request tag}; -> LOOKUP (replay, now a hit; store then merges and sets dirty).
- RESPOND: resp_valid=1 for exactly one cycle; -> IDLE.
- Column counter wraps at COLUMNS; burst length always exactly COLUMNS words.
- mem_cmd_valid, once raised, holds with stable fields until mem_cmd_ready.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_data=0, mem_cmd_valid=0, mem_cmd_write=0, mem_cmd_address=0, mem_wvalid=0, mem_wdata=0.
- rst at any state, including mid-burst: next cycle state=INIT, all outputs at reset values; in-flight burst abandoned (memory side is reset together).
- INIT lasts exactly LINES cycles; req_ready rises the cycle after.
- Hit latency: accept at cycle T, resp_valid at T+2, req_ready back high at T+3.
- Miss latency: T+2 + memory handshake cycles + COLUMNS refill beats (+ COLUMNS writeback beats if dirty) + replay.
- req_ready low in every state except IDLE; req_valid while not ready is ignored and must be held by the CPU.
- mem_rvalid outside RF_DATA is ignored.

## Test plan
- Reset -> req_ready low for exactly LINES (256) cycles, then high; every first access misses.
- Load 0x0000_0010 on cold cache -> RF_CMD address 0x0000_0010, 4 refill words 0xA0..0xA3 -> resp_data 0xA0 (column 0); second load 0x0000_0014 -> hit, resp_valid at T+2, data 0xA1.
- Store 0xDEAD_BEEF strobe 4'b0011 to resident word 0x11223344 -> later load returns 0x1122BEEF, no memory traffic.
- Dirty line at 0x0000_0000, then load 0x0000_1000 (same line index, LINE_IX=8) -> write burst at 0x0000_0000 with 4 words incl. merged data, then read burst at 0x0000_1000.
- mem_cmd_ready held low 5 cycles and mem_wready toggled -> command fields stable, write words neither dropped nor duplicated.
- rst asserted mid RF_DATA -> INIT sweep restarts; subsequent load of same address misses and refills.
